// File: rtl/wb_pipeline_master_nb_pkg.sv
// Shared bus geometry, CTI codes and FSM encoding for the NIC WISHBONE pipelined master.
package wb_pipeline_master_nb_pkg;
  localparam int BUS_ADDRESS_WIDTH = 32;
  localparam int BUS_DATA_WIDTH    = 32;
  localparam int GRANULARITY       = 8;
  localparam int MAX_BURST_LENGHT  = 8;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_XFER = 2'd2,
    ST_END  = 2'd3
  } state_t;
endpackage

// File: rtl/wb_ack_watchdog.sv
// Counts consecutive cycles with beats outstanding and no ACK; flags the cycle the limit is hit.
module wb_ack_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic expire
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] cnt;

  // Any cycle without the enable (an ACK arrived or nothing outstanding) restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (!en)               cnt <= '0;
    else if (cnt != LAST)       cnt <= cnt + 1'b1;
  end

  assign expire = (TIMEOUT_CYCLES > 0) && en && (cnt == LAST);
endmodule

// File: rtl/wb_pipeline_master_nb.sv
// WISHBONE B4 pipelined master: one job of up to N_WORDS single beats on one CYC,
// ACK collection, read data packed into rdata_o, done/err pulse back to the NIC core.
module wb_pipeline_master_nb
  import wb_pipeline_master_nb_pkg::*;
#(
  parameter int N_WORDS        = MAX_BURST_LENGHT,
  parameter int N_BITS_LEN     = $clog2(N_WORDS + 1),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    req_i,
  input  logic                                    we_i,
  input  logic [BUS_ADDRESS_WIDTH-1:0]            adr_i,
  input  logic [N_BITS_LEN-1:0]                   len_i,
  input  logic [N_WORDS*BUS_DATA_WIDTH-1:0]       wdata_i,
  output logic                                    busy_o,
  output logic                                    done_o,
  output logic                                    err_o,
  output logic [N_WORDS*BUS_DATA_WIDTH-1:0]       rdata_o,
  output logic                                    req_wb_o,
  input  logic                                    gnt_wb_i,
  output logic                                    CYC_O,
  output logic                                    STB_O,
  output logic                                    WE_O,
  output logic [BUS_ADDRESS_WIDTH-1:0]            ADR_O,
  output logic [BUS_DATA_WIDTH-1:0]               DAT_O,
  output logic [BUS_DATA_WIDTH/GRANULARITY-1:0]   SEL_O,
  output logic [2:0]                              CTI_O,
  input  logic [BUS_DATA_WIDTH-1:0]               DAT_I,
  input  logic                                    ACK_I,
  input  logic                                    ERR_I,
  input  logic                                    RTY_I,
  input  logic                                    STALL_I
);
  localparam int DW = BUS_DATA_WIDTH;
  localparam int AW = BUS_ADDRESS_WIDTH;
  localparam int IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  state_t                      state;
  logic                        we_q;
  logic [AW-1:0]               adr_q;
  logic [N_BITS_LEN-1:0]       len_q, issued, acked, issued_nxt, acked_nxt;
  logic [N_WORDS-1:0][DW-1:0]  wdata_q, rdata_q;
  logic                        in_xfer, beat, resp_ok, abort, wd_en, wd_expire;

  // ERR/RTY take priority over a same-cycle ACK; ACKs with nothing outstanding are dropped.
  always_comb begin
    in_xfer    = (state == ST_XFER);
    beat       = in_xfer && STB_O && !STALL_I;
    resp_ok    = in_xfer && ACK_I && !ERR_I && !RTY_I && (acked < issued);
    wd_en      = in_xfer && (issued > acked) && !ACK_I;
    abort      = in_xfer && (ERR_I || RTY_I || wd_expire);
    issued_nxt = issued + N_BITS_LEN'(beat);
    acked_nxt  = acked + N_BITS_LEN'(resp_ok);
  end

  wb_ack_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .en     (wd_en),
    .expire (wd_expire)
  );

  assign rdata_o = rdata_q;
  assign CTI_O   = CTI_CLASSIC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      we_q     <= 1'b0;
      adr_q    <= '0;
      len_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      issued   <= '0;
      acked    <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      req_wb_o <= 1'b0;
      CYC_O    <= 1'b0;
      STB_O    <= 1'b0;
      WE_O     <= 1'b0;
      ADR_O    <= '0;
      DAT_O    <= '0;
      SEL_O    <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        ST_IDLE: if (req_i) begin
          we_q    <= we_i;
          adr_q   <= adr_i;
          len_q   <= len_i;
          wdata_q <= wdata_i;
          busy_o  <= 1'b1;
          if (len_i == '0) begin
            state  <= ST_END;
            done_o <= 1'b1;
            err_o  <= 1'b1;
          end else begin
            req_wb_o <= 1'b1;
            state    <= ST_ARB;
          end
        end
        ST_ARB: if (gnt_wb_i) begin
          CYC_O  <= 1'b1;
          STB_O  <= 1'b1;
          WE_O   <= we_q;
          ADR_O  <= adr_q;
          SEL_O  <= '1;
          DAT_O  <= we_q ? wdata_q[0] : '0;
          issued <= '0;
          acked  <= '0;
          if (!we_q) rdata_q <= '0;
          state  <= ST_XFER;
        end
        ST_XFER: begin
          issued <= issued_nxt;
          acked  <= acked_nxt;
          if (resp_ok && !we_q) rdata_q[acked[IW-1:0]] <= DAT_I;
          if (abort || (acked_nxt == len_q)) begin
            state    <= ST_END;
            done_o   <= 1'b1;
            err_o    <= abort;
            req_wb_o <= 1'b0;
            CYC_O    <= 1'b0;
            STB_O    <= 1'b0;
            WE_O     <= 1'b0;
            ADR_O    <= '0;
            DAT_O    <= '0;
            SEL_O    <= '0;
          end else begin
            // A stalled beat leaves STB_O/DAT_O untouched; an accepted one moves to the next word.
            STB_O <= (issued_nxt < len_q);
            if (beat && we_q && (issued_nxt < len_q)) DAT_O <= wdata_q[issued_nxt[IW-1:0]];
          end
        end
        ST_END: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_pipeline_master_nb.sv
// Scoreboard bench: a random pipelined slave checks every beat, a monitor checks each done_o
// against the job result predicted from the job description and the slave's response plan.
module tb_wb_pipeline_master_nb;
  import wb_pipeline_master_nb_pkg::*;

  localparam int NW = MAX_BURST_LENGHT;
  localparam int DW = BUS_DATA_WIDTH;
  localparam int AW = BUS_ADDRESS_WIDTH;
  localparam int SW = DW / GRANULARITY;
  localparam int LW = $clog2(NW + 1);
  localparam int BW = NW * DW;
  localparam int TO = 8;

  logic clk, rst, req_i, we_i, busy_o, done_o, err_o, req_wb_o, gnt_wb_i;
  logic [AW-1:0] adr_i, ADR_O;
  logic [LW-1:0] len_i;
  logic [BW-1:0] wdata_i, rdata_o;
  logic CYC_O, STB_O, WE_O, ACK_I, ERR_I, RTY_I, STALL_I;
  logic [DW-1:0] DAT_O, DAT_I;
  logic [SW-1:0] SEL_O;
  logic [2:0] CTI_O;

  wb_pipeline_master_nb #(.N_WORDS(NW), .N_BITS_LEN(LW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .adr_i(adr_i), .len_i(len_i),
    .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .req_wb_o(req_wb_o), .gnt_wb_i(gnt_wb_i), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .CTI_O(CTI_O), .DAT_I(DAT_I),
    .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I), .STALL_I(STALL_I)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit            err;
    logic [BW-1:0] rdata;
    int            beats;
    bit            chk_beats;
    int            outc;
    bit            chk_outc;
  } exp_t;

  exp_t exp_q[$];
  int   pend[$];
  int   tests = 0, fails = 0;

  // Current job as seen by the slave, and slave behaviour knobs.
  bit            cur_we;
  logic [AW-1:0] cur_adr;
  int            cur_len;
  logic [BW-1:0] cur_wdata;
  logic [BW-1:0] model_rdata = '0;
  int beats = 0, resps = 0, out_cycles = 0, n_done = 0, wait_cnt = 0;
  int stall_pct = 0, ack_pct = 100, gnt_pct = 100, err_at = 0;
  bit err_rty = 0, no_ack = 0, drop_chk = 0;

  function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a, input int k);
    logic [7:0] lo;
    lo = 8'hA0 + 8'(k);
    return {a[23:0], lo};
  endfunction

  task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Pipelined slave: decides STALL/ACK/ERR for the coming edge, checks each accepted beat.
  initial begin
    int k;
    gnt_wb_i = 0; ACK_I = 0; ERR_I = 0; RTY_I = 0; STALL_I = 0; DAT_I = '0;
    forever begin
      @(negedge clk);
      if (drop_chk && !rst) check("cyc_drop", BW'({CYC_O, STB_O, done_o}), BW'(3'b001));
      drop_chk = 0;
      if (CYC_O && pend.size() > 0) out_cycles++;
      gnt_wb_i = req_wb_o && ($urandom_range(99) < gnt_pct);
      ACK_I = 0; ERR_I = 0; RTY_I = 0; DAT_I = $urandom;
      if (rst || !CYC_O) begin
        pend.delete(); STALL_I = 0; wait_cnt = 0;
        continue;
      end
      if (pend.size() > 0 && !no_ack) begin
        if ($urandom_range(99) < ack_pct || wait_cnt >= 2) begin
          k = pend.pop_front(); resps++; wait_cnt = 0;
          if (resps == err_at) begin
            if (err_rty) RTY_I = 1; else ERR_I = 1;
            drop_chk = 1;
          end else begin
            ACK_I = 1; DAT_I = rd_word(cur_adr, k);
            if (resps == cur_len) drop_chk = 1;
          end
        end else wait_cnt++;
      end
      STALL_I = ($urandom_range(99) < stall_pct);
      if (STB_O && !STALL_I) begin
        if (beats >= cur_len) begin
          tests++; fails++;
          $display("FAIL extra_beat: beat %0d issued, len %0d", beats, cur_len);
        end else begin
          check("beat_adr", BW'(ADR_O), BW'(cur_adr));
          check("beat_ctl", BW'({WE_O, SEL_O, CTI_O}), BW'({cur_we, {SW{1'b1}}, 3'b000}));
          if (cur_we) check("beat_dat", BW'(DAT_O), BW'(cur_wdata[beats*DW +: DW]));
        end
        pend.push_back(beats);
        beats++;
      end
    end
  end

  // Monitor: every done_o pops one expected job result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done_o) begin
        n_done++;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: done_o with no job pending");
        end else begin
          e = exp_q.pop_front();
          check("job_err", BW'(err_o), BW'(e.err));
          check("job_rdata", rdata_o, e.rdata);
          if (e.chk_beats) check("job_beats", BW'(beats), BW'(e.beats));
          if (e.chk_outc) check("timeout_cycles", BW'(out_cycles), BW'(e.outc));
        end
      end
    end
  end

  task automatic start_job(input bit we, input logic [AW-1:0] adr, input int len,
                           input logic [BW-1:0] wd);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy_o) begin ok = 1; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL idle_wait: busy_o still high after 50 cycles");
    end
    cur_we = we; cur_adr = adr; cur_len = len; cur_wdata = wd;
    beats = 0; resps = 0; out_cycles = 0;
    req_i = 1; we_i = we; adr_i = adr; len_i = LW'(len); wdata_i = wd;
  endtask

  task automatic run_job(input bit we, input logic [AW-1:0] adr, input int len,
                         input logic [BW-1:0] wd);
    exp_t e;
    int start, nfill;
    bit ok = 0, bus_err;
    bus_err = (err_at != 0 && err_at <= len);
    e.err = (len == 0) || no_ack || bus_err;
    if (!we && len > 0) begin
      model_rdata = '0;
      nfill = no_ack ? 0 : bus_err ? err_at - 1 : len;
      for (int k = 0; k < nfill; k++) model_rdata[k*DW +: DW] = rd_word(adr, k);
    end
    e.rdata = model_rdata;
    e.beats = len;
    e.chk_beats = !e.err || (len == 0);
    e.outc = TO;
    e.chk_outc = no_ack && (len > 0);
    start_job(we, adr, len, wd);
    exp_q.push_back(e);
    start = n_done;
    @(negedge clk);
    req_i = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (n_done != start) begin ok = 1; break; end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL job_done: no done_o within 400 cycles");
      exp_q.delete();
    end
  endtask

  function automatic logic [BW-1:0] rand_wd();
    logic [BW-1:0] w;
    for (int k = 0; k < NW; k++) w[k*DW +: DW] = $urandom;
    return w;
  endfunction

  initial begin
    bit ok;
    rst = 1; req_i = 0; we_i = 0; adr_i = '0; len_i = '0; wdata_i = '0;
    repeat (3) @(negedge clk);
    check("rst_ctl", BW'({busy_o, done_o, err_o, req_wb_o, CYC_O, STB_O, WE_O}), '0);
    check("rst_bus", BW'({ADR_O, DAT_O, SEL_O, CTI_O}), '0);
    check("rst_rdata", rdata_o, '0);
    rst = 0;

    // Back-to-back write, read, stalled write.
    run_job(1, 32'h1000_0040, 4, rand_wd());
    run_job(0, 32'h2000_0080, 4, '0);
    stall_pct = 50;
    run_job(1, 32'h3000_00C0, 4, rand_wd());
    stall_pct = 0;

    // ERR on the 2nd response of a 3-beat read, RTY on a write, zero-length job.
    err_at = 2;
    run_job(0, 32'h4000_0100, 3, '0);
    err_rty = 1; err_at = 1;
    run_job(1, 32'h5000_0140, 2, rand_wd());
    err_rty = 0; err_at = 0;
    run_job(1, 32'h6000_0180, 0, rand_wd());

    // Slave never answers: watchdog abort.
    no_ack = 1;
    run_job(1, 32'h7000_01C0, 2, rand_wd());

    // Async reset in the middle of a transfer.
    start_job(0, 32'h8000_0200, 3, '0);
    @(negedge clk);
    req_i = 0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (CYC_O) begin ok = 1; break; end
    end
    check("rst_mid_reached_xfer", BW'(ok), BW'(1'b1));
    @(negedge clk);
    #1 rst = 1;
    #1 check("rst_mid_ctl", BW'({CYC_O, STB_O, req_wb_o, busy_o, done_o}), '0);
    check("rst_mid_rdata", rdata_o, '0);
    model_rdata = '0;
    exp_q.delete();
    @(negedge clk);
    rst = 0; no_ack = 0;
    run_job(0, 32'h9000_0240, 2, '0);

    // Randomized jobs.
    for (int n = 0; n < 40; n++) begin
      int len;
      len       = $urandom_range(NW, 1);
      stall_pct = ($urandom_range(1) == 1) ? 50 : 0;
      ack_pct   = $urandom_range(100, 50);
      gnt_pct   = $urandom_range(100, 30);
      err_rty   = $urandom_range(1);
      err_at    = ($urandom_range(4) == 0) ? $urandom_range(len, 1) : 0;
      run_job($urandom_range(1), $urandom, len, rand_wd());
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
